// File: rtl/io_map_pkg.sv
// Address map and SRAM strobe encodings shared by the I/O manager and its decoder.
package io_map_pkg;

    localparam logic [15:0] RLED_ADDR = 16'hFFF0;
    localparam logic [15:0] GLED_ADDR = 16'hFFF1;
    localparam logic [15:0] IO_BASE   = 16'hFFF0;

    // Bit positions inside sram_control = {ce_n, oe_n, we_n, ub_n, lb_n}
    localparam int CE_BIT = 4;
    localparam int OE_BIT = 3;
    localparam int WE_BIT = 2;
    localparam int UB_BIT = 1;
    localparam int LB_BIT = 0;

    localparam logic [4:0] SRAM_IDLE = 5'b11111;
    localparam logic [4:0] SRAM_RD   = 5'b00100;
    localparam logic [4:0] SRAM_WR   = 5'b01000;

endpackage

// File: rtl/io_addr_decoder.sv
// Splits the CPU address space into SRAM and I/O, and flags writes to the LED registers.
module io_addr_decoder
    import io_map_pkg::*;
(
    input  logic [15:0] direcciones_cpu,
    input  logic        oe,
    output logic        sram_sel,
    output logic        rled_we,
    output logic        gled_we
);

    logic io_sel;

    assign io_sel   = (direcciones_cpu >= IO_BASE);
    assign sram_sel = !io_sel;
    assign rled_we  = oe && (direcciones_cpu == RLED_ADDR);
    assign gled_we  = oe && (direcciones_cpu == GLED_ADDR);

endmodule

// File: rtl/io_manager_unit.sv
// Memory-mapped I/O manager: SRAM strobe generation, SRAM address pass-through and LED registers.
module io_manager_unit
    import io_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] direcciones_cpu,
    input  logic [15:0] led_data,
    input  logic        oe,
    output logic [4:0]  sram_control,
    output logic [9:0]  r_led,
    output logic [7:0]  g_led,
    output logic [17:0] direcciones
);

    logic       sram_sel;
    logic       rled_we;
    logic       gled_we;
    logic [9:0] r_led_reg;
    logic [7:0] g_led_reg;
    logic       unused_data_hi;

    io_addr_decoder u_decoder (
        .direcciones_cpu (direcciones_cpu),
        .oe              (oe),
        .sram_sel        (sram_sel),
        .rled_we         (rled_we),
        .gled_we         (gled_we)
    );

    // The board only wires A15..A0; the upper SRAM address pins stay low.
    assign direcciones = {2'b00, direcciones_cpu};

    // Reset gates the strobes combinationally so the SRAM deselects in the same cycle.
    always_comb begin
        sram_control = SRAM_IDLE;
        if (!reset && sram_sel) begin
            sram_control = oe ? SRAM_WR : SRAM_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_reg <= '0;
            g_led_reg <= '0;
        end else begin
            if (rled_we) begin
                r_led_reg <= led_data[9:0];
            end
            if (gled_we) begin
                g_led_reg <= led_data[7:0];
            end
        end
    end

    assign r_led = r_led_reg;
    assign g_led = g_led_reg;

    // Data bits above the widest LED register carry no meaning here.
    assign unused_data_hi = ^led_data[15:10];

endmodule

// File: tb/tb_io_manager_unit.sv
// Directed plus randomized checks of io_manager_unit against a behavioural address-map model.
module tb_io_manager_unit;

    logic        clk;
    logic        reset;
    logic [15:0] direcciones_cpu;
    logic [15:0] led_data;
    logic        oe;
    logic [4:0]  sram_control;
    logic [9:0]  r_led;
    logic [7:0]  g_led;
    logic [17:0] direcciones;

    int errors = 0;
    int checks = 0;

    logic [9:0] model_r = '0;
    logic [7:0] model_g = '0;

    io_manager_unit dut (
        .clk             (clk),
        .reset           (reset),
        .direcciones_cpu (direcciones_cpu),
        .led_data        (led_data),
        .oe              (oe),
        .sram_control    (sram_control),
        .r_led           (r_led),
        .g_led           (g_led),
        .direcciones     (direcciones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    // Strobes derived from active-low semantics: chip enabled for any SRAM address,
    // output enable low on reads, write enable low on writes, both byte lanes on.
    function automatic logic [4:0] expect_ctrl(input logic r, input logic [15:0] a, input logic o);
        logic ce_n, oe_n, we_n;
        if (r || a >= 16'hFFF0) return 5'b11111;
        ce_n = 1'b0;
        oe_n = o;
        we_n = !o;
        return {ce_n, oe_n, we_n, 1'b0, 1'b0};
    endfunction

    // One bus cycle: drive, check combinational outputs, clock, check LED registers.
    task automatic cycle(input logic r, input logic [15:0] a, input logic o, input logic [15:0] d);
        reset = r;
        direcciones_cpu = a;
        oe = o;
        led_data = d;
        #1;
        check("sram_control", {13'd0, sram_control}, {13'd0, expect_ctrl(r, a, o)});
        check("direcciones", direcciones, {2'b00, a});
        check("strobe_excl", {17'd0, (!sram_control[3] && !sram_control[2])}, 18'd0);
        @(posedge clk);
        if (r) begin
            model_r = '0;
            model_g = '0;
        end else if (o) begin
            if (a == 16'hFFF0) model_r = d[9:0];
            if (a == 16'hFFF1) model_g = d[7:0];
        end
        #1;
        check("r_led", {8'd0, r_led}, {8'd0, model_r});
        check("g_led", {10'd0, g_led}, {10'd0, model_g});
        $display("txn reset=%0d addr=%h oe=%0d data=%h ctrl=%b r_led=%h g_led=%h",
                 r, a, o, d, sram_control, r_led, g_led);
        @(negedge clk);
    endtask

    initial begin
        logic        r;
        logic [15:0] a;
        logic        o;
        logic [15:0] d;

        // Reset held with a write pending to the red LED address
        cycle(1'b1, 16'hFFF0, 1'b1, 16'h03FF);
        cycle(1'b1, 16'hFFF0, 1'b1, 16'h03FF);
        check("reset_r_led", {8'd0, r_led}, 18'd0);

        // SRAM write then read at the same address
        cycle(1'b0, 16'h1234, 1'b1, 16'h5555);
        check("sram_wr_ctrl", {13'd0, sram_control}, 18'b01000);
        cycle(1'b0, 16'h1234, 1'b0, 16'h5555);
        check("sram_rd_ctrl", {13'd0, sram_control}, 18'b00100);
        check("sram_rd_addr", direcciones, 18'h01234);

        // Red LED write keeps only the low ten bits
        cycle(1'b0, 16'hFFF0, 1'b1, 16'hABCD);
        check("rled_val", {8'd0, r_led}, 18'h3CD);
        check("rled_g_hold", {10'd0, g_led}, 18'h0);

        // Green LED write, then a read of the same address must not disturb it
        cycle(1'b0, 16'hFFF1, 1'b1, 16'h00A5);
        check("gled_val", {10'd0, g_led}, 18'hA5);
        cycle(1'b0, 16'hFFF1, 1'b0, 16'hFFFF);
        check("gled_hold", {10'd0, g_led}, 18'hA5);

        // Last SRAM address, first SRAM address, unused I/O write
        cycle(1'b0, 16'hFFEF, 1'b1, 16'h0000);
        check("bound_ffef", {13'd0, sram_control}, 18'b01000);
        cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
        check("bound_0000", {13'd0, sram_control}, 18'b00100);
        cycle(1'b0, 16'hFFF5, 1'b1, 16'hFFFF);
        check("unused_io_ctrl", {13'd0, sram_control}, 18'b11111);
        check("unused_io_r", {8'd0, r_led}, 18'h3CD);
        check("unused_io_g", {10'd0, g_led}, 18'hA5);

        // Reset wins over a simultaneous red LED write
        cycle(1'b1, 16'hFFF0, 1'b1, 16'h0155);
        check("reset_prio", {8'd0, r_led}, 18'h0);

        // Randomized traffic biased toward the SRAM/I/O boundary
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom);
                1:       a = 16'hFFF0 + 16'($urandom_range(0, 15));
                2:       a = 16'hFFEE + 16'($urandom_range(0, 3));
                default: a = ($urandom_range(0, 1) == 0) ? 16'hFFF0 : 16'hFFF1;
            endcase
            r = ($urandom_range(0, 15) == 0);
            o = 1'($urandom);
            d = 16'($urandom);
            cycle(r, a, o, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
